mdu32_iter: RTL and testbench

Iterative unsigned multiply/divide unit in the CPU execute stage. It takes two 32-bit operands read from the 32-entry register file (read ports A and B) and computes over 32 cycles. It returns one 32-bit result through a one-cycle writeback strobe that drives the register file's write port (busw/rw/we). The pipeline controller stalls on busy.

---
 rtl/mdu32_iter.sv | 131 +++++++++++++
 tb/tb_mdu32_iter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu32_iter.sv
// Iterative 32-bit unsigned multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, result returned through a one-cycle register-file write strobe.
module mdu32_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    input  logic [4:0]      rd,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] wb_busw,
    output logic [4:0]      wb_rw,
    output logic            wb_we
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [1:0]      r_op;
    logic [XLEN-1:0] r_opnd;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [4:0]      r_rd;
    logic [4:0]      r_cnt;

    logic            w_accept;
    logic            w_div_zero;
    logic            w_last;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic            w_ge;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_hi_d;
    logic [XLEN-1:0] w_lo_d;
    logic [XLEN-1:0] w_result;

    assign w_accept   = (r_state == StIdle) && start;
    assign w_div_zero = op[1] && (opb == '0);
    assign w_last     = (r_state == StRun) && (r_cnt == 5'd31);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d = w_div_zero ? StDone : StRun;
                end
            end
            StRun: begin
                if (r_cnt == 5'd31) begin
                    w_state_d = StDone;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        busy  = (r_state != StIdle);
        done  = (r_state == StDone);
        wb_we = (r_state == StDone) && (r_rd != '0);
    end

    // r_hi/r_lo hold the product accumulator (multiply) or remainder/quotient (divide).
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_shift = {r_hi, r_lo[XLEN-1]};
        w_ge    = (w_shift >= {1'b0, r_opnd});
        // Remainder stays below the divisor, so the low XLEN bits of the difference suffice.
        w_diff  = w_shift[XLEN-1:0] - r_opnd;
        if (r_op[1]) begin
            w_hi_d = w_ge ? w_diff : w_shift[XLEN-1:0];
            w_lo_d = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_hi_d = w_sum[XLEN:1];
            w_lo_d = {w_sum[0], r_lo[XLEN-1:1]};
        end
        w_result = r_op[0] ? w_hi_d : w_lo_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= '0;
            r_opnd  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            wb_busw <= '0;
            wb_rw   <= '0;
        end else if (w_accept) begin
            r_op   <= op;
            r_opnd <= op[1] ? opb : opa;
            r_lo   <= op[1] ? opa : opb;
            r_hi   <= '0;
            r_rd   <= rd;
            r_cnt  <= '0;
            if (w_div_zero) begin
                wb_busw <= op[0] ? opa : '1;
                wb_rw   <= rd;
            end
        end else if (r_state == StRun) begin
            r_cnt <= r_cnt + 5'd1;
            r_hi  <= w_hi_d;
            r_lo  <= w_lo_d;
            if (w_last) begin
                wb_busw <= w_result;
                wb_rw   <= r_rd;
            end
        end
    end

endmodule

// File: tb/tb_mdu32_iter.sv
// Scoreboard bench for mdu32_iter: expected results are queued at issue and
// compared against the writeback port whenever done pulses.
module tb_mdu32_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [4:0]  rd;
    logic        busy;
    logic        done;
    logic [31:0] wb_busw;
    logic [4:0]  wb_rw;
    logic        wb_we;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   cyc      = 0;

    mdu32_iter #(.XLEN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .opa     (opa),
        .opb     (opb),
        .rd      (rd),
        .busy    (busy),
        .done    (done),
        .wb_busw (wb_busw),
        .wb_rw   (wb_rw),
        .wb_we   (wb_we)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (o)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    always @(negedge clk) begin
        if (wb_we && !done) check_eq("we_without_done", {31'b0, wb_we}, 32'd0);
        if (done) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                check_eq("unexpected_done", {31'b0, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("wb_busw", wb_busw, e.res);
                check_eq("wb_rw", {27'b0, wb_rw}, {27'b0, e.rd});
                check_eq("wb_we", {31'b0, wb_we}, {31'b0, (e.rd != 5'd0)});
                check_eq("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d);
        exp_t e;
        @(negedge clk);
        op    = o;
        opa   = a;
        opb   = b;
        rd    = d;
        start = 1'b1;
        e.res       = model(o, a, b);
        e.rd        = d;
        e.lat       = (o[1] && b == 0) ? 1 : 33;
        e.start_cyc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        opa   = $urandom;
        opb   = $urandom;
        rd    = 5'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) ok = 1'b1;
        end
        if (!ok) begin
            check_eq("idle_timeout", 32'(sb.size()) | {31'b0, busy}, 32'd0);
            sb.delete();
        end
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check_eq({tag, "_done"}, {31'b0, done}, 32'd0);
        check_eq({tag, "_we"}, {31'b0, wb_we}, 32'd0);
        check_eq({tag, "_busw"}, wb_busw, 32'd0);
        check_eq({tag, "_rw"}, {27'b0, wb_rw}, 32'd0);
    endtask

    initial begin
        int n0;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;

        rst   = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        opa   = 32'd0;
        opb   = 32'd0;
        rd    = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;

        // MUL 7x6 -> 42, busy from the cycle after start, done low afterwards
        issue(2'd0, 32'd7, 32'd6, 5'd5);
        @(negedge clk);
        check_eq("mul_busy", {31'b0, busy}, 32'd1);
        wait_idle(40);
        check_eq("mul_done_low", {31'b0, done}, 32'd0);

        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
        wait_idle(40);
        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        wait_idle(40);

        issue(2'd2, 32'd100, 32'd7, 5'd3);
        wait_idle(40);
        issue(2'd3, 32'd100, 32'd7, 5'd3);
        wait_idle(40);
        issue(2'd2, 32'h8000_0000, 32'd1, 5'd6);
        wait_idle(40);

        // Divide by zero: done right after start, busy for one cycle only
        issue(2'd2, 32'h1234, 32'd0, 5'd9);
        @(negedge clk);
        check_eq("div0_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check_eq("div0_busy_end", {31'b0, busy}, 32'd0);
        issue(2'd3, 32'h1234, 32'd0, 5'd10);
        wait_idle(10);

        // rd=0 never written; a start mid-run is ignored
        n0 = n_done;
        issue(2'd0, 32'd3, 32'd3, 5'd0);
        repeat (9) @(negedge clk);
        op    = 2'd0;
        opa   = 32'd5;
        opb   = 32'd5;
        rd    = 5'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(40);
        repeat (40) @(negedge clk);
        check_eq("single_done", 32'(n_done - n0), 32'd1);

        // Reset mid-divide aborts without a write strobe
        issue(2'd2, 32'd1000, 32'd10, 5'd4);
        repeat (10) @(negedge clk);
        void'(sb.pop_front());
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_cleared("abort");
        n0 = n_done;
        repeat (40) @(negedge clk);
        check_eq("abort_no_done", 32'(n_done - n0), 32'd0);
        issue(2'd2, 32'd1000, 32'd10, 5'd4);
        wait_idle(40);

        for (int i = 0; i < 8; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = (i == 5) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 5000)));
            issue(o, a, b, 5'($urandom_range(0, 31)));
            wait_idle(40);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
